// File: rtl/rom_uploader.sv
// rom_uploader: serves hps_io upload reads from the BRAM/SDRAM/constant ROM byte map.
// Optional SDRAM ack watchdog: define ROM_UPLOAD_TIMEOUT_EN.
module rom_uploader #(
  parameter int SD_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        upload_en,
  input  logic [25:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic [25:0] bram_addr,
  output logic        bram_68k_rd,
  output logic        bram_z80_rd,
  output logic        bram_prom1_rd,
  output logic        bram_prom2_rd,
  input  logic [15:0] bram_68k_q,
  input  logic [7:0]  bram_z80_q,
  input  logic [7:0]  bram_prom1_q,
  input  logic [7:0]  bram_prom2_q,
  output logic        sdram_req,
  output logic [24:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_q
);
  typedef enum logic [3:0] {IDLE, DECODE, B16, B8_LO, B8_HI, LATCH, SD_REQ, SD_WAIT, DONE} state_t;
  typedef enum logic [3:0] {
    R_68K, R_Z80, R_TILES, R_SPRITES, R_K007232, R_UPD7759, R_THEME, R_PROM1, R_PROM2, R_NONE
  } region_t;
  // region start addresses in map order; the last entry is the end of the map
  localparam logic [25:0] region_base [10] = '{
    26'h000000, 26'h060000, 26'h068000, 26'h168000, 26'h368000,
    26'h388000, 26'h3A8000, 26'h428000, 26'h428100, 26'h428200
  };
  state_t state, state_nx;
  region_t rg;
  logic [25:0] a, base, o, sd_sum;
  logic [7:0] lo, q8;
  logic [15:0] dbuf, din_nx;
  logic sd_to;
  always_comb begin
    rg = R_NONE;
    base = region_base[9];
    for (int i = 8; i >= 0; i--)
      if (a < region_base[i+1]) begin
        rg = region_t'(4'(i));
        base = region_base[i];
      end
  end
  assign o = a - base;
  assign sd_sum = o + (rg == R_SPRITES ? 26'h200000 : rg == R_THEME ? 26'h400000 : 26'h000000);
  assign q8 = rg == R_Z80 ? bram_z80_q : rg == R_PROM1 ? bram_prom1_q : bram_prom2_q;
  assign din_nx = state == LATCH ? (rg == R_68K ? bram_68k_q : {q8, lo}) :
                  state == SD_WAIT ? (sdram_ack ? sdram_q : 16'hDEAD) :
                  (rg == R_NONE ? 16'h0000 : 16'hFFFF);
`ifdef ROM_UPLOAD_TIMEOUT_EN
  logic [7:0] to_cnt;
  always_ff @(posedge clk_sys) begin
    if (reset || state != SD_WAIT) to_cnt <= 8'd0;
    else to_cnt <= to_cnt + 8'd1;
  end
  assign sd_to = to_cnt == 8'(SD_TIMEOUT - 1);
`else
  assign sd_to = 1'b0;
`endif
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ioctl_rd && upload_en ? DECODE : IDLE;
      DECODE:  state_nx = rg == R_68K ? B16 :
                          (rg == R_Z80 || rg == R_PROM1 || rg == R_PROM2) ? B8_LO :
                          (rg == R_TILES || rg == R_SPRITES || rg == R_THEME) ? SD_REQ : DONE;
      B16:     state_nx = LATCH;
      B8_LO:   state_nx = B8_HI;
      B8_HI:   state_nx = LATCH;
      LATCH:   state_nx = DONE;
      SD_REQ:  state_nx = SD_WAIT;
      SD_WAIT: state_nx = sdram_ack || sd_to ? DONE : SD_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bram_68k_rd = state == B16;
    bram_z80_rd = (state == B8_LO || state == B8_HI) && rg == R_Z80;
    bram_prom1_rd = (state == B8_LO || state == B8_HI) && rg == R_PROM1;
    bram_prom2_rd = (state == B8_LO || state == B8_HI) && rg == R_PROM2;
    bram_addr = state == B16 ? o >> 1 : state == B8_HI ? o + 26'd1 : o;
    sdram_req = state == SD_WAIT;
    sdram_addr = sd_sum[25:1];
  end
  // result is staged in dbuf and published to the host only while leaving DONE
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      a <= '0;
      lo <= '0;
      dbuf <= '0;
      ioctl_din <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      if (state == IDLE && state_nx == DECODE) a <= ioctl_addr & ~26'd1;
      if (state == B8_HI) lo <= q8;
      if (state_nx == DONE) dbuf <= din_nx;
      if (state == DONE) ioctl_din <= dbuf;
      ioctl_wait <= state_nx != IDLE;
    end
  end
endmodule

// File: tb/tb_rom_uploader.sv
// tb_rom_uploader: scoreboard bench for rom_uploader; BRAM/SDRAM behavioural responders.
// SDRAM ack delay sd_lat counts edges from the req-rise edge to the edge that samples ack.
module tb_rom_uploader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        upload_en = 1'b0;
  logic [25:0] ioctl_addr = '0;
  logic        ioctl_rd = 1'b0;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic [25:0] bram_addr;
  logic        bram_68k_rd, bram_z80_rd, bram_prom1_rd, bram_prom2_rd;
  logic [15:0] bram_68k_q = '0;
  logic [7:0]  bram_z80_q = '0, bram_prom1_q = '0, bram_prom2_q = '0;
  logic        sdram_req;
  logic [24:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic [15:0] sdram_q = '0;

  typedef struct {logic [25:0] a; logic [15:0] d; int lat; int start;} exp_t;
  typedef struct {logic [25:0] a; logic [15:0] d; int lat; int n;} vec_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, sd_lat = 0, sd_cnt = 0;
  int n68 = 0, nz80 = 0, np1 = 0, np2 = 0, excl_viol = 0, sd_move = 0;
  logic prev_wait = 1'b0, prev_req = 1'b0, rst_edge = 1'b1, wait_seen;
  logic [24:0] prev_sd_addr = '0;

  rom_uploader dut (
    .clk_sys(clk_sys), .reset(reset), .upload_en(upload_en),
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .bram_addr(bram_addr), .bram_68k_rd(bram_68k_rd), .bram_z80_rd(bram_z80_rd),
    .bram_prom1_rd(bram_prom1_rd), .bram_prom2_rd(bram_prom2_rd),
    .bram_68k_q(bram_68k_q), .bram_z80_q(bram_z80_q),
    .bram_prom1_q(bram_prom1_q), .bram_prom2_q(bram_prom2_q),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_q(sdram_q)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] f68(input logic [25:0] a);
    return a == 26'd1 ? 16'h4E71 : {a[7:0], ~a[7:0]};
  endfunction
  function automatic logic [7:0] fz80(input logic [25:0] a);
    return a == 26'h10 ? 8'h3E : a == 26'h11 ? 8'hC9 : a[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [15:0] fsd(input logic [24:0] a);
    return a == 25'h100002 ? 16'hA55A : a[15:0] ^ 16'h1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // memory and SDRAM responders
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    rst_edge <= reset;
    if (bram_68k_rd) begin bram_68k_q <= f68(bram_addr); n68 <= n68 + 1; end
    if (bram_z80_rd) begin bram_z80_q <= fz80(bram_addr); nz80 <= nz80 + 1; end
    if (bram_prom1_rd) begin bram_prom1_q <= bram_addr[7:0] + 8'h11; np1 <= np1 + 1; end
    if (bram_prom2_rd) begin bram_prom2_q <= bram_addr[7:0] ^ 8'hF0; np2 <= np2 + 1; end
    if (!sdram_req) begin
      sd_cnt <= 0;
      sdram_ack <= 1'b0;
    end else begin
      sd_cnt <= sd_cnt + 1;
      sdram_ack <= sd_lat != 0 && sd_cnt + 1 == sd_lat - 1;
      sdram_q <= fsd(sdram_addr);
    end
  end

  // monitor: pops the scoreboard whenever ioctl_wait falls outside reset
  always @(negedge clk_sys) begin
    if (int'(bram_68k_rd) + int'(bram_z80_rd) + int'(bram_prom1_rd) + int'(bram_prom2_rd) + int'(sdram_req) > 1)
      excl_viol++;
    if (sdram_req && prev_req && sdram_addr != prev_sd_addr) sd_move++;
    if (prev_wait && !ioctl_wait && !rst_edge) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got din 0x%0h with no read outstanding, want none", ioctl_din);
      end else begin
        e = sb.pop_front();
        chk($sformatf("din@%0h", e.a), 32'(ioctl_din), 32'(e.d));
        chk($sformatf("latency@%0h", e.a), 32'(cyc - e.start - 1), 32'(e.lat));
      end
    end
    prev_wait = ioctl_wait;
    prev_req = sdram_req;
    prev_sd_addr = sdram_addr;
  end

  task automatic issue(input logic [25:0] addr, input logic [15:0] d, input int lat, input bit push);
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_rd = 1'b1;
    if (push) sb.push_back('{addr, d, lat, cyc});
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d reads outstanding after %0d cycles, want 0", sb.size(), n);
      sb.delete();
    end
    repeat (2) @(negedge clk_sys);
  endtask

  vec_t vecs[14] = '{
    '{26'h000002, 16'h4E71, 4, 0}, '{26'h05FFFE, 16'hFF00, 4, 0}, '{26'h000003, 16'h4E71, 4, 0},
    '{26'h060010, 16'hC93E, 5, 0}, '{26'h067FFE, 16'hA5A4, 5, 0},
    '{26'h428000, 16'h1211, 5, 0}, '{26'h428102, 16'hF3F2, 5, 0},
    '{26'h168004, 16'hA55A, 10, 7}, '{26'h068010, 16'h123C, 5, 2}, '{26'h3A8006, 16'h1237, 6, 3},
    '{26'h368000, 16'hFFFF, 2, 0}, '{26'h3A7FFE, 16'hFFFF, 2, 0},
    '{26'h428200, 16'h0000, 2, 0}, '{26'h3FFFFFF, 16'h0000, 2, 0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_din", 32'(ioctl_din), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_strobes", 32'({bram_68k_rd, bram_z80_rd, bram_prom1_rd, bram_prom2_rd}), 0);
    chk("rst_bram_addr", 32'(bram_addr), 0);
    chk("rst_sdram_addr", 32'(sdram_addr), 0);
    reset = 1'b0;
    upload_en = 1'b1;
    foreach (vecs[i]) begin
      sd_lat = vecs[i].n;
      issue(vecs[i].a, vecs[i].d, vecs[i].lat, 1'b1);
      drain();
    end
    // a second rd while busy must be dropped
    sd_lat = 7;
    issue(26'h168004, 16'hA55A, 10, 1'b1);
    @(negedge clk_sys);
    issue(26'h368000, 16'h0, 0, 1'b0);
    drain();
    // upload_en falling mid-transaction does not abort it
    issue(26'h000004, 16'h02FD, 4, 1'b1);
    upload_en = 1'b0;
    drain();
    issue(26'h000002, 16'h0, 0, 1'b0);
    wait_seen = ioctl_wait;
    repeat (3) begin
      @(negedge clk_sys);
      wait_seen |= ioctl_wait;
    end
    chk("wait_while_disabled", 32'(wait_seen), 0);
    upload_en = 1'b1;
    // reset while stuck in SD_WAIT
    sd_lat = 0;
    issue(26'h168004, 16'h0, 0, 1'b0);
    repeat (4) @(negedge clk_sys);
    chk("req_before_reset", 32'(sdram_req), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("req_after_reset", 32'(sdram_req), 0);
    chk("wait_after_reset", 32'(ioctl_wait), 0);
    reset = 1'b0;
    issue(26'h000000, 16'h00FF, 4, 1'b1);
    drain();
`ifdef ROM_UPLOAD_TIMEOUT_EN
    sd_lat = 0;
    issue(26'h168004, 16'hDEAD, 258, 1'b1);
    drain();
    chk("req_after_timeout", 32'(sdram_req), 0);
`endif
    chk("n_68k_strobes", 32'(n68), 5);
    chk("n_z80_strobes", 32'(nz80), 4);
    chk("n_prom1_strobes", 32'(np1), 2);
    chk("n_prom2_strobes", 32'(np2), 2);
    chk("strobe_exclusive", 32'(excl_viol), 0);
    chk("sdram_addr_stable", 32'(sd_move), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
